// File: rtl/timer.sv
// Programmable down-counter timer with one-shot and auto-reload modes.
// Three bus registers (CTRL, PRESET, COUNT) and a maskable interrupt request.
module timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        WE,
    input  logic [31:0] Wdata,
    output logic [31:0] Rdata,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    state_t      state_reg, state_next;
    logic [3:0]  ctrl_reg, ctrl_next;
    logic [31:0] preset_reg, preset_next;
    logic [31:0] count_reg, count_next;
    logic        irq_flag_reg, irq_flag_next;

    logic        enable;
    logic        auto_reload;
    logic        wr_ctrl;
    logic        wr_preset;

    assign enable      = ctrl_reg[0];
    assign auto_reload = (ctrl_reg[2:1] == 2'b01);
    assign wr_ctrl     = WE && (addr == ADDR_CTRL);
    assign wr_preset   = WE && (addr == ADDR_PRESET);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            ctrl_reg     <= 4'd0;
            preset_reg   <= 32'd0;
            count_reg    <= 32'd0;
            irq_flag_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ctrl_reg     <= ctrl_next;
            preset_reg   <= preset_next;
            count_reg    <= count_next;
            irq_flag_reg <= irq_flag_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ctrl_next     = ctrl_reg;
        preset_next   = preset_reg;
        count_next    = count_reg;
        irq_flag_next = irq_flag_reg;

        // Bus writes first; an expiring count below still raises the flag
        // in the same cycle so an interrupt is never lost to a write.
        if (wr_preset) begin
            preset_next = Wdata;
            if (!auto_reload) begin
                irq_flag_next = 1'b0;
            end
        end
        if (wr_ctrl) begin
            ctrl_next     = Wdata[3:0];
            irq_flag_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                count_next = preset_reg;
                state_next = CNT;
            end
            CNT: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (count_reg > 32'd1) begin
                    count_next = count_reg - 32'd1;
                end else begin
                    // PRESET=0 lands here too, so it behaves like PRESET=1
                    count_next    = 32'd0;
                    state_next    = INT;
                    irq_flag_next = 1'b1;
                end
            end
            INT: begin
                if (auto_reload) begin
                    state_next    = LOAD;
                    irq_flag_next = 1'b0;
                end else begin
                    state_next = IDLE;
                    if (!wr_ctrl) begin
                        ctrl_next[0] = 1'b0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        case (addr)
            ADDR_CTRL:   Rdata = {28'd0, ctrl_reg};
            ADDR_PRESET: Rdata = preset_reg;
            ADDR_COUNT:  Rdata = count_reg;
            default:     Rdata = 32'd0;
        endcase
    end

    assign IRQ = irq_flag_reg & ctrl_reg[3];

endmodule

// File: tb/tb_timer.sv
// Directed self-checking bench for the timer: one task per scenario,
// each comparing register reads and IRQ against hand-computed values.
module tb_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic        WE = 1'b0;
    logic [31:0] Wdata = 32'd0;
    logic [31:0] Rdata;
    logic        IRQ;

    int n_cmp = 0;
    int n_err = 0;

    timer dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .WE    (WE),
        .Wdata (Wdata),
        .Rdata (Rdata),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write lands on the next rising edge; returns 1 time unit after it.
    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        Wdata = d;
        WE    = 1'b1;
        @(posedge clk);
        #1;
        WE    = 1'b0;
        Wdata = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = Rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq: got %b expected 0", IRQ);
        end
        for (int a = 0; a < 3; a++) begin
            rd(a[1:0], d);
            n_cmp++;
            if (d !== 32'd0) begin
                n_err++;
                $display("FAIL reset_reg%0d: got %h expected 0", a, d);
            end
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_one_shot();
        logic [31:0] d;
        logic [31:0] exp_cnt [1:6] = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
        logic        exp_irq [1:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] exp_ctl [1:6] = '{32'h9, 32'h9, 32'h9, 32'h9, 32'h9, 32'h8};
        write_reg(2'd1, 32'd3);
        write_reg(2'd0, 32'h9);
        for (int k = 1; k <= 6; k++) begin
            tick();
            rd(2'd2, d);
            n_cmp++;
            if (d !== exp_cnt[k]) begin
                n_err++;
                $display("FAIL oneshot_count E%0d: got %0d expected %0d", k, d, exp_cnt[k]);
            end
            n_cmp++;
            if (IRQ !== exp_irq[k]) begin
                n_err++;
                $display("FAIL oneshot_irq E%0d: got %b expected %b", k, IRQ, exp_irq[k]);
            end
            rd(2'd0, d);
            n_cmp++;
            if (d !== exp_ctl[k]) begin
                n_err++;
                $display("FAIL oneshot_ctrl E%0d: got %h expected %h", k, d, exp_ctl[k]);
            end
        end
        repeat (3) tick();
        n_cmp++;
        if (IRQ !== 1'b1) begin
            n_err++;
            $display("FAIL oneshot_irq_held: got %b expected 1", IRQ);
        end
        write_reg(2'd1, 32'd7);
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL preset_write_clears_irq: got %b expected 0", IRQ);
        end
        rd(2'd1, d);
        n_cmp++;
        if (d !== 32'd7) begin
            n_err++;
            $display("FAIL preset_readback: got %0d expected 7", d);
        end
        $display("test_one_shot done");
    endtask

    task automatic test_auto_reload();
        logic [31:0] d;
        logic [31:0] exp_c;
        logic        exp_i;
        write_reg(2'd1, 32'd2);
        write_reg(2'd0, 32'hB);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) begin
                exp_c = 32'd0;
            end else begin
                case ((k - 2) % 4)
                    0:       exp_c = 32'd2;
                    1:       exp_c = 32'd1;
                    default: exp_c = 32'd0;
                endcase
            end
            exp_i = (k >= 4) && (k % 4 == 0);
            rd(2'd2, d);
            n_cmp++;
            if (d !== exp_c) begin
                n_err++;
                $display("FAIL reload_count E%0d: got %0d expected %0d", k, d, exp_c);
            end
            n_cmp++;
            if (IRQ !== exp_i) begin
                n_err++;
                $display("FAIL reload_irq E%0d: got %b expected %b", k, IRQ, exp_i);
            end
        end
        rd(2'd0, d);
        n_cmp++;
        if (d !== 32'hB) begin
            n_err++;
            $display("FAIL reload_ctrl: got %h expected b", d);
        end
        write_reg(2'd0, 32'h0);
        tick();
        tick();
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL reload_stop_irq: got %b expected 0", IRQ);
        end
        $display("test_auto_reload done");
    endtask

    task automatic test_masked();
        logic [31:0] d;
        write_reg(2'd1, 32'd1);
        write_reg(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_cmp++;
            if (IRQ !== 1'b0) begin
                n_err++;
                $display("FAIL masked_irq E%0d: got %b expected 0", k, IRQ);
            end
            rd(2'd0, d);
            n_cmp++;
            if (d !== ((k <= 3) ? 32'h1 : 32'h0)) begin
                n_err++;
                $display("FAIL masked_ctrl E%0d: got %h expected %h", k, d, (k <= 3) ? 1 : 0);
            end
            if (k >= 2) begin
                rd(2'd2, d);
                n_cmp++;
                if (d !== ((k == 2) ? 32'd1 : 32'd0)) begin
                    n_err++;
                    $display("FAIL masked_count E%0d: got %0d expected %0d", k, d, (k == 2) ? 1 : 0);
                end
            end
        end
        $display("test_masked done");
    endtask

    task automatic test_preset_zero_mode10();
        logic [31:0] d;
        write_reg(2'd1, 32'd0);
        write_reg(2'd0, 32'hD);
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++;
            if (IRQ !== (k >= 3)) begin
                n_err++;
                $display("FAIL preset0_irq E%0d: got %b expected %b", k, IRQ, k >= 3);
            end
            rd(2'd0, d);
            n_cmp++;
            if (d !== ((k <= 3) ? 32'hD : 32'hC)) begin
                n_err++;
                $display("FAIL mode10_ctrl E%0d: got %h expected %h", k, d, (k <= 3) ? 32'hD : 32'hC);
            end
        end
        write_reg(2'd0, 32'h8);
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL ctrl_write_clears_irq: got %b expected 0", IRQ);
        end
        $display("test_preset_zero_mode10 done");
    endtask

    task automatic test_ctrl_write_in_int();
        logic [31:0] d;
        write_reg(2'd1, 32'd1);
        write_reg(2'd0, 32'h9);
        repeat (3) tick();
        n_cmp++;
        if (IRQ !== 1'b1) begin
            n_err++;
            $display("FAIL int_irq: got %b expected 1", IRQ);
        end
        write_reg(2'd0, 32'hB);
        rd(2'd0, d);
        n_cmp++;
        if (d !== 32'hB) begin
            n_err++;
            $display("FAIL cpu_write_wins_ctrl: got %h expected b", d);
        end
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL cpu_write_wins_irq: got %b expected 0", IRQ);
        end
        tick();
        tick();
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'd1) begin
            n_err++;
            $display("FAIL restart_count: got %0d expected 1", d);
        end
        tick();
        n_cmp++;
        if (IRQ !== 1'b1) begin
            n_err++;
            $display("FAIL restart_irq: got %b expected 1", IRQ);
        end
        tick();
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL restart_pulse_end: got %b expected 0", IRQ);
        end
        write_reg(2'd0, 32'h0);
        tick();
        $display("test_ctrl_write_in_int done");
    endtask

    task automatic test_disable_hold();
        logic [31:0] d;
        write_reg(2'd1, 32'd10);
        write_reg(2'd0, 32'h1);
        repeat (6) tick();
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'd6) begin
            n_err++;
            $display("FAIL hold_precount: got %0d expected 6", d);
        end
        write_reg(2'd0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            rd(2'd2, d);
            n_cmp++;
            if (d !== 32'd5) begin
                n_err++;
                $display("FAIL hold_count step%0d: got %0d expected 5", k, d);
            end
            n_cmp++;
            if (IRQ !== 1'b0) begin
                n_err++;
                $display("FAIL hold_irq step%0d: got %b expected 0", k, IRQ);
            end
        end
        write_reg(2'd0, 32'h1);
        tick();
        tick();
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'd10) begin
            n_err++;
            $display("FAIL reenable_load: got %0d expected 10", d);
        end
        write_reg(2'd1, 32'd20);
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'd9) begin
            n_err++;
            $display("FAIL preset_during_cnt_count: got %0d expected 9", d);
        end
        rd(2'd1, d);
        n_cmp++;
        if (d !== 32'd20) begin
            n_err++;
            $display("FAIL preset_during_cnt_preset: got %0d expected 20", d);
        end
        write_reg(2'd0, 32'h0);
        tick();
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'd8) begin
            n_err++;
            $display("FAIL second_hold: got %0d expected 8", d);
        end
        write_reg(2'd0, 32'h1);
        tick();
        tick();
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'd20) begin
            n_err++;
            $display("FAIL new_preset_applied: got %0d expected 20", d);
        end
        write_reg(2'd0, 32'h0);
        tick();
        tick();
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'd19) begin
            n_err++;
            $display("FAIL final_hold: got %0d expected 19", d);
        end
        $display("test_disable_hold done");
    endtask

    task automatic test_ignored_and_reset();
        logic [31:0] d;
        write_reg(2'd2, 32'h1234);
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'd19) begin
            n_err++;
            $display("FAIL count_readonly: got %h expected 13", d);
        end
        write_reg(2'd3, 32'hFFFF_FFFF);
        rd(2'd0, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL addr3_write_ctrl: got %h expected 0", d);
        end
        rd(2'd1, d);
        n_cmp++;
        if (d !== 32'd20) begin
            n_err++;
            $display("FAIL addr3_write_preset: got %0d expected 20", d);
        end
        rd(2'd3, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL addr3_read: got %h expected 0", d);
        end
        write_reg(2'd1, 32'd100);
        write_reg(2'd0, 32'h9);
        repeat (5) tick();
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'd97) begin
            n_err++;
            $display("FAIL midcount: got %0d expected 97", d);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_irq: got %b expected 0", IRQ);
        end
        for (int a = 0; a < 3; a++) begin
            rd(a[1:0], d);
            n_cmp++;
            if (d !== 32'd0) begin
                n_err++;
                $display("FAIL async_reset_reg%0d: got %h expected 0", a, d);
            end
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick();
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'd0) begin
            n_err++;
            $display("FAIL post_reset_count: got %0d expected 0", d);
        end
        rd(2'd0, d);
        n_cmp++;
        if (d !== 32'd0) begin
            n_err++;
            $display("FAIL post_reset_ctrl: got %h expected 0", d);
        end
        $display("test_ignored_and_reset done");
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_masked();
        test_preset_zero_mode10();
        test_ctrl_write_in_int();
        test_disable_hold();
        test_ignored_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
